// File: rtl/aes_round_sequencer.sv
// Control FSM for the AES-128 round datapath: issues one-cycle stage load strobes,
// waits out each stage's latency, counts rounds and rejects non-data headers.
module aes_round_sequencer #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter logic [3:0]  VALID_HDR  = 4'h7,
  parameter int unsigned SUB_LAT    = 4,
  parameter int unsigned SHIFT_LAT  = 1,
  parameter int unsigned MIX_LAT    = 2,
  parameter int unsigned ARK_LAT    = 1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [3:0] header_in,
  input  logic       abort,
  output logic       sub_load,
  output logic       shift_load,
  output logic       mix_load,
  output logic       ark_load,
  output logic [3:0] round,
  output logic       busy,
  output logic       done,
  output logic       reject
);

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    StIdle,
    StArk0,
    StSub,
    StShift,
    StMix,
    StArk,
    StDone
  } state_e;

  state_e     state_q;
  logic [3:0] round_q;
  logic [3:0] wait_q;
  logic       sub_load_q, shift_load_q, mix_load_q, ark_load_q;
  logic       busy_q, done_q, reject_q;

  logic [3:0] stage_lat;
  logic       stage_end;

  always_comb begin
    stage_lat = 4'd0;
    case (state_q)
      StArk0, StArk: stage_lat = 4'(ARK_LAT);
      StSub:         stage_lat = 4'(SUB_LAT);
      StShift:       stage_lat = 4'(SHIFT_LAT);
      StMix:         stage_lat = 4'(MIX_LAT);
      default:       stage_lat = 4'd0;
    endcase
    // A stage state lasts 1+LAT cycles: the wait counter runs 0..LAT.
    stage_end = (wait_q == stage_lat);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= StIdle;
      round_q      <= 4'd0;
      wait_q       <= 4'd0;
      sub_load_q   <= 1'b0;
      shift_load_q <= 1'b0;
      mix_load_q   <= 1'b0;
      ark_load_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      reject_q     <= 1'b0;
    end else begin
      // Strobes and pulses default low; each is set only on the edge entering its state.
      sub_load_q   <= 1'b0;
      shift_load_q <= 1'b0;
      mix_load_q   <= 1'b0;
      ark_load_q   <= 1'b0;
      done_q       <= 1'b0;
      reject_q     <= 1'b0;
      wait_q       <= wait_q + 4'd1;
      if (state_q != StIdle && abort) begin
        state_q <= StIdle;
        round_q <= 4'd0;
        wait_q  <= 4'd0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            wait_q <= 4'd0;
            if (start) begin
              if (header_in == VALID_HDR) begin
                state_q    <= StArk0;
                round_q    <= 4'd0;
                ark_load_q <= 1'b1;
                busy_q     <= 1'b1;
              end else begin
                reject_q <= 1'b1;
              end
            end
          end
          StArk0: begin
            if (stage_end) begin
              state_q    <= StSub;
              round_q    <= round_q + 4'd1;
              wait_q     <= 4'd0;
              sub_load_q <= 1'b1;
            end
          end
          StSub: begin
            if (stage_end) begin
              state_q      <= StShift;
              wait_q       <= 4'd0;
              shift_load_q <= 1'b1;
            end
          end
          StShift: begin
            if (stage_end) begin
              wait_q <= 4'd0;
              if (round_q < LastRound) begin
                state_q    <= StMix;
                mix_load_q <= 1'b1;
              end else begin
                state_q    <= StArk;
                ark_load_q <= 1'b1;
              end
            end
          end
          StMix: begin
            if (stage_end) begin
              state_q    <= StArk;
              wait_q     <= 4'd0;
              ark_load_q <= 1'b1;
            end
          end
          StArk: begin
            if (stage_end) begin
              wait_q <= 4'd0;
              if (round_q == LastRound) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q    <= StSub;
                round_q    <= round_q + 4'd1;
                sub_load_q <= 1'b1;
              end
            end
          end
          StDone: begin
            state_q <= StIdle;
            wait_q  <= 4'd0;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
            wait_q  <= 4'd0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sub_load   = sub_load_q;
  assign shift_load = shift_load_q;
  assign mix_load   = mix_load_q;
  assign ark_load   = ark_load_q;
  assign round      = round_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign reject     = reject_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: expected done/reject events are queued at
// start time and matched (kind and cycle) when the DUT pulses them.
module tb_aes_round_sequencer;

  localparam int Lat = 119;

  logic       tb_clk = 1'b0;
  logic       n_rst;
  logic       start;
  logic [3:0] header_in;
  logic       abort;
  logic       sub_load, shift_load, mix_load, ark_load;
  logic [3:0] round;
  logic       busy, done, reject;

  aes_round_sequencer dut (
    .clk        (tb_clk),
    .n_rst      (n_rst),
    .start      (start),
    .header_in  (header_in),
    .abort      (abort),
    .sub_load   (sub_load),
    .shift_load (shift_load),
    .mix_load   (mix_load),
    .ark_load   (ark_load),
    .round      (round),
    .busy       (busy),
    .done       (done),
    .reject     (reject)
  );

  always #5 tb_clk = ~tb_clk;

  int cyc = 0;
  always @(posedge tb_clk) cyc <= cyc + 1;

  // kind is {done, reject}
  typedef struct {
    logic [1:0] kind;
    int         cycle;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errs   = 0;
  int ark_n, sub_n, shift_n, mix_n, multi_n, mix10_n, busy_n, done_n, reject_n;
  int done_cyc, fall_cyc;
  logic [3:0] sub_round, shift_round, ark_round, max_round;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_counts();
    ark_n = 0; sub_n = 0; shift_n = 0; mix_n = 0; multi_n = 0; mix10_n = 0;
    busy_n = 0; done_n = 0; reject_n = 0; done_cyc = -1; fall_cyc = -1;
    sub_round = 4'd0; shift_round = 4'd0; ark_round = 4'd0; max_round = 4'd0;
  endtask

  task automatic monitor();
    exp_t e;
    logic busy_prev;
    busy_prev = 1'b0;
    forever begin
      @(negedge tb_clk);
      if (n_rst) begin
        if (ark_load)   begin ark_n++;   ark_round = round;   end
        if (sub_load)   begin sub_n++;   sub_round = round;   end
        if (shift_load) begin shift_n++; shift_round = round; end
        if (mix_load)   mix_n++;
        if ($countones({sub_load, shift_load, mix_load, ark_load}) > 1) multi_n++;
        if (mix_load && round == 4'd10) mix10_n++;
        if (round > max_round) max_round = round;
        if (busy) busy_n++;
        if (busy_prev && !busy) fall_cyc = cyc;
        busy_prev = busy;
        if (done) begin done_n++; done_cyc = cyc; end
        if (reject) reject_n++;
        if (done || reject) begin
          if (sb.size() == 0) begin
            check("unexpected_evt", {30'd0, done, reject}, 32'd0);
          end else begin
            e = sb.pop_front();
            check("evt_kind", {30'd0, done, reject}, {30'd0, e.kind});
            check("evt_cycle", cyc, e.cycle);
          end
        end
      end else begin
        busy_prev = 1'b0;
      end
    end
  endtask

  task automatic do_start(input logic [3:0] hdr);
    exp_t e;
    @(negedge tb_clk);
    start     = 1'b1;
    header_in = hdr;
    @(posedge tb_clk);
    #1;
    start     = 1'b0;
    header_in = 4'h0;
    if (hdr == 4'h7) begin
      e.kind = 2'b10; e.cycle = cyc + Lat;
    end else begin
      e.kind = 2'b01; e.cycle = cyc;
    end
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge tb_clk);
      n++;
    end
    check("sb_drain", sb.size(), 0);
  endtask

  task automatic check_full_run(input string tag);
    check({tag, "_ark_n"}, ark_n, 11);
    check({tag, "_sub_n"}, sub_n, 10);
    check({tag, "_shift_n"}, shift_n, 10);
    check({tag, "_mix_n"}, mix_n, 9);
    check({tag, "_done_n"}, done_n, 1);
    check({tag, "_multi_load"}, multi_n, 0);
  endtask

  function automatic logic [31:0] outs();
    return {21'd0, sub_load, shift_load, mix_load, ark_load, round, busy, done, reject};
  endfunction

  initial begin
    int acc;
    int n;
    n_rst = 1'b0; start = 1'b0; abort = 1'b0; header_in = 4'h0;
    clear_counts();
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge tb_clk);
    check("reset_outputs", outs(), 32'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge tb_clk);

    // Valid block: strobe counts, final-round skip, done timing, busy fall
    clear_counts();
    do_start(4'h7);
    drain(200);
    repeat (3) @(negedge tb_clk);
    check_full_run("valid");
    check("mix_in_round10", mix10_n, 0);
    check("last_sub_round", sub_round, 10);
    check("last_shift_round", shift_round, 10);
    check("last_ark_round", ark_round, 10);
    check("max_round", max_round, 10);
    check("busy_fall", fall_cyc, done_cyc + 1);
    check("busy_after_done", busy, 0);

    // Invalid header
    clear_counts();
    do_start(4'h0);
    drain(10);
    repeat (3) @(negedge tb_clk);
    check("inv_reject_n", reject_n, 1);
    check("inv_busy_n", busy_n, 0);
    check("inv_loads", ark_n + sub_n + shift_n + mix_n, 0);

    // Start while busy is ignored
    clear_counts();
    do_start(4'h7);
    acc = cyc;
    while (cyc < acc + 49) @(negedge tb_clk);
    start = 1'b1; header_in = 4'h7;
    @(posedge tb_clk);
    #1;
    start = 1'b0; header_in = 4'h0;
    drain(200);
    repeat (3) @(negedge tb_clk);
    check_full_run("busy_start");
    check("busy_start_reject", reject_n, 0);

    // Abort in round 5
    clear_counts();
    do_start(4'h7);
    n = 0;
    while (round != 4'd5 && n < 200) begin
      @(negedge tb_clk);
      n++;
    end
    check("abort_round", round, 5);
    abort = 1'b1;
    @(posedge tb_clk);
    #1;
    abort = 1'b0;
    sb.delete();
    clear_counts();
    @(negedge tb_clk);
    check("abort_outputs", outs(), 32'd0);
    repeat (150) @(negedge tb_clk);
    check("abort_done_n", done_n, 0);
    check("abort_loads", ark_n + sub_n + shift_n + mix_n, 0);
    check("abort_busy_n", busy_n, 0);
    clear_counts();
    do_start(4'h7);
    drain(200);
    repeat (3) @(negedge tb_clk);
    check_full_run("post_abort");

    // Asynchronous reset mid-SUB
    clear_counts();
    do_start(4'h7);
    n = 0;
    while (!sub_load && n < 50) begin
      @(negedge tb_clk);
      n++;
    end
    check("sub_seen", sub_load, 1);
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst_outputs", outs(), 32'd0);
    sb.delete();
    repeat (2) @(negedge tb_clk);
    n_rst = 1'b1;
    clear_counts();
    repeat (130) @(negedge tb_clk);
    check("rst_done_n", done_n, 0);
    check("rst_busy_n", busy_n, 0);
    do_start(4'h7);
    drain(200);
    repeat (3) @(negedge tb_clk);
    check_full_run("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
